// File: rtl/montgomery_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// montgomery_mult
//
// Bit-serial radix-2 Montgomery multiplier. It computes P = A*B*R^-1 mod N,
// where R = 2^BITS. One operand bit is consumed per RUN cycle. A single FIX
// cycle then loads the result register. Each operation takes BITS+2 cycles
// from the start edge to the next possible start edge.
//
// Optional feature macro: MONTGOMERY_MULT_FINAL_SUB_EN
//   defined   : FIX performs the conditional final subtraction, so P < N
//   undefined : P = S with no subtraction, so P < 2N. This form is suitable
//               for chained Montgomery use when N < R/4.
//   The latency is the same in both builds.
//
// Parameters
//   BITS     operand and result width
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-high reset
//   start    request an operation; it is sampled only in IDLE
//   A, B     operands; each must be less than N
//   N        modulus; it must be odd and less than R/4
//   N_prime  -N^-1 mod R; only bit 0 is used
//   busy     high from the cycle after acceptance until done
//   done     one-cycle pulse; P is valid from this cycle
//   P        registered result; it holds until the next done
// -----------------------------------------------------------------------------
module montgomery_mult #(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [BITS-1:0] A,
  input  logic [BITS-1:0] B,
  input  logic [BITS-1:0] N,
  input  logic [BITS-1:0] N_prime,
  output logic            busy,
  output logic            done,
  output logic [BITS-1:0] P
);

  localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int SW = BITS + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BITS-1:0] a_q, a_d;
  logic [BITS-1:0] b_q, b_d;
  logic [BITS-1:0] n_q, n_d;
  logic            np0_q, np0_d;
  logic [SW-1:0]   s_q, s_d;
  logic [CW-1:0]   i_q, i_d;
  logic [BITS-1:0] p_q, p_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Only the LSB of N_prime matters in radix 2.
  logic unused_np;
  assign unused_np = ^N_prime[BITS-1:1];

  // One Montgomery step. S < 2N and B < N give t < 3N. Adding q*N keeps the
  // sum below 4N < R, so the BITS+2 wide datapath cannot overflow.
  logic [SW-1:0]   t_sum;
  logic            q_bit;
  logic [SW-1:0]   s_step;
  logic [BITS-1:0] p_fix;

  always_comb begin
    t_sum  = s_q + (a_q[i_q] ? {2'b00, b_q} : {SW{1'b0}});
    q_bit  = t_sum[0] & np0_q;
    s_step = (t_sum + (q_bit ? {2'b00, n_q} : {SW{1'b0}})) >> 1;
`ifdef MONTGOMERY_MULT_FINAL_SUB_EN
    // S < 2N < R/2, so the low BITS bits hold S and S-N exactly.
    p_fix  = (s_q >= {2'b00, n_q}) ? (s_q[BITS-1:0] - n_q) : s_q[BITS-1:0];
`else
    p_fix  = s_q[BITS-1:0];
`endif
  end

  // NOTE: every signal driven here receives a default first. This prevents a
  // latch on any path that does not assign it.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    n_d     = n_q;
    np0_d   = np0_q;
    s_d     = s_q;
    i_d     = i_q;
    p_d     = p_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          n_d     = N;
          np0_d   = N_prime[0];
          s_d     = '0;
          i_d     = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d = s_step;
        if (i_q == CW'(BITS - 1)) begin
          i_d     = '0;
          state_d = FIX;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      FIX: begin
        p_d     = p_fix;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. Every flop
  // then samples its _d value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      np0_q   <= 1'b0;
      s_q     <= '0;
      i_q     <= '0;
      p_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      np0_q   <= np0_d;
      s_q     <= s_d;
      i_q     <= i_d;
      p_q     <= p_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the operand registers have no reset. They are always loaded on
  // acceptance before anything reads them, so a reset would only add fan-out.
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
    n_q <= n_d;
  end

  assign busy = busy_q;
  assign done = done_q;
  assign P    = p_q;

endmodule

// File: tb/tb_montgomery_mult.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_montgomery_mult
//
// This bench drives two instances of the multiplier: one with BITS=8 for the
// directed cases and one with BITS=32 for the random back-to-back regression.
// The reference computes (A*B mod N) * 2^-BITS mod N by repeated modular
// halving. The expected form of P follows MONTGOMERY_MULT_FINAL_SUB_EN.
// -----------------------------------------------------------------------------
module tb_montgomery_mult;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       s8_start, s8_busy, s8_done;
  logic [7:0] s8_a, s8_b, s8_n, s8_np, s8_p;

  logic        s32_start, s32_busy, s32_done;
  logic [31:0] s32_a, s32_b, s32_n, s32_np, s32_p;

  montgomery_mult #(.BITS(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .A(s8_a), .B(s8_b), .N(s8_n),
    .N_prime(s8_np), .busy(s8_busy), .done(s8_done), .P(s8_p)
  );

  montgomery_mult #(.BITS(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(s32_start), .A(s32_a), .B(s32_b), .N(s32_n),
    .N_prime(s32_np), .busy(s32_busy), .done(s32_done), .P(s32_p)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Montgomery product by definition: x = A*B mod N, then divide by 2 mod N
  // BITS times.
  function automatic longint unsigned mont_ref(input longint unsigned a,
      input longint unsigned b, input longint unsigned n, input int bits);
    longint unsigned x;
    x = (a * b) % n;
    for (int k = 0; k < bits; k++)
      x = x[0] ? (x + n) >> 1 : x >> 1;
    return x;
  endfunction

  task automatic check_p(input string tag, input longint unsigned p,
                         input longint unsigned n, input longint unsigned exp);
`ifdef MONTGOMERY_MULT_FINAL_SUB_EN
    check(tag, p, exp);
    check({tag, "_lt_n"}, longint'(p < n), 1);
`else
    check({tag, "_mod"}, p % n, exp);
    check({tag, "_lt_2n"}, longint'(p < 2 * n), 1);
`endif
  endtask

  // Runs one 8-bit operation and returns P plus the number of edges from the
  // accepting edge to the edge after which done is observed high.
  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] n, input logic [7:0] np,
                     output longint unsigned p, output int lat);
    s8_a = a; s8_b = b; s8_n = n; s8_np = np; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    check("busy8_after_start", s8_busy, 1);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (s8_done) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) check("timeout8", 0, 1);
    else check("busy8_at_done", s8_busy, 0);
    p = s8_p;
  endtask

  localparam int NUM = 20;
  longint unsigned ra[NUM], rb[NUM], rn[NUM];

  task automatic drive32(input int j);
    s32_a = 32'(ra[j]); s32_b = 32'(rb[j]); s32_n = 32'(rn[j]);
    s32_np = 32'h1;  // only bit 0 matters
  endtask

  initial begin
    longint unsigned p;
    int lat, dones, done_c, prev_cyc;
    bit got;

    rst = 1'b1;
    s8_start = 0; s8_a = 0; s8_b = 0; s8_n = 0; s8_np = 0;
    s32_start = 0; s32_a = 0; s32_b = 0; s32_n = 0; s32_np = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_p8", s8_p, 0);
    check("rst_done8", s8_done, 0);
    check("rst_busy8", s8_busy, 0);
    check("rst_p32", s32_p, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed 8-bit cases with N=13 and N_prime=59.
    op8(8'd5, 8'd7, 8'd13, 8'd59, p, lat);
    check("lat_5x7", lat, 9);
    check_p("p_5x7", p, 13, mont_ref(5, 7, 13, 8));
    check_p("p_5x7_lit", p, 13, 1);

    op8(8'd12, 8'd12, 8'd13, 8'd59, p, lat);
    check("lat_12x12", lat, 9);
    check_p("p_12x12", p, 13, 3);

    op8(8'd0, 8'd9, 8'd13, 8'd59, p, lat);
    check("p_0x9", p, 0);
    op8(8'd7, 8'd0, 8'd13, 8'd59, p, lat);
    check("p_7x0", p, 0);

    // Even modulus: the result is undefined, but the latency must not change.
    op8(8'd9, 8'd5, 8'd12, 8'd0, p, lat);
    check("lat_even_n", lat, 9);

    // Start pulses and operand changes during RUN must be ignored.
    s8_a = 8'd5; s8_b = 8'd7; s8_n = 8'd13; s8_np = 8'd59; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    dones = 0; done_c = 0; p = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c >= 2 && c <= 4) begin
        s8_start = 1'b1; s8_a = 8'd12; s8_b = 8'd12; s8_n = 8'd11;
      end else begin
        s8_start = 1'b0;
      end
      if (s8_done) begin
        dones++;
        done_c = c;
        p = s8_p;
      end
    end
    check("ignore_dones", dones, 1);
    check("ignore_lat", done_c, 9);
    check_p("ignore_p", p, 13, 1);

    // Reset mid-RUN: the outputs clear at once, and no done follows.
    s8_a = 8'd12; s8_b = 8'd12; s8_n = 8'd13; s8_np = 8'd59; s8_start = 1'b1;
    @(posedge clk); #1;
    s8_start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_p", s8_p, 0);
    check("midrst_done", s8_done, 0);
    check("midrst_busy", s8_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    dones = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (s8_done) dones++;
    end
    check("midrst_no_done", dones, 0);

    op8(8'd12, 8'd12, 8'd13, 8'd59, p, lat);
    check("post_rst_lat", lat, 9);
    check_p("post_rst_p", p, 13, 3);

    // Random 32-bit regression with start held high between operations.
    for (int j = 0; j < NUM; j++) begin
      rn[j] = longint'(($urandom & 32'h3fff_ffff) | 32'h3);
      ra[j] = longint'($urandom) % rn[j];
      rb[j] = longint'($urandom) % rn[j];
    end
    rb[1] = rn[1] - 1;
    ra[1] = rn[1] - 1;
    drive32(0);
    s32_start = 1'b1;
    @(posedge clk); #1;
    check("busy32_first", s32_busy, 1);
    drive32(1);
    prev_cyc = 0;
    for (int j = 0; j < NUM; j++) begin
      got = 1'b0;
      for (int c = 1; c <= 60; c++) begin
        @(posedge clk); #1;
        if (s32_done) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) begin
        check("timeout32", 0, 1);
        break;
      end
      check_p("rand32", s32_p, rn[j], mont_ref(ra[j], rb[j], rn[j], 32));
      if (j > 0) check("spacing32", longint'(cyc - prev_cyc), 34);
      prev_cyc = cyc;
      if (j < NUM - 1) begin
        @(posedge clk); #1;
        check("busy32_b2b", s32_busy, 1);
        if (j + 2 < NUM) drive32(j + 2);
        else s32_start = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
